// File: rtl/channel_mask_scan_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | channel_mask_scan_controller_pkg: mask command codes, discri patterns,  |
// | scan FSM state encoding.                                  Rev 1.0       |
// +--------------------------------------------------------------------------+
package channel_mask_scan_controller_pkg;

  localparam logic [2:0] MASK_CMD_NONE   = 3'b000;
  localparam logic [2:0] MASK_CMD_MASK   = 3'b001;
  localparam logic [2:0] MASK_CMD_UNMASK = 3'b010;
  localparam logic [2:0] MASK_CMD_CLEAR  = 3'b011;
  localparam logic [2:0] MASK_CMD_ALL    = 3'b100;

  localparam logic [2:0] DISCRI_ALL_MASKED  = 3'b000;
  localparam logic [2:0] DISCRI_NONE_MASKED = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_MASK_ALL = 4'd1,
    ST_UNMASK   = 4'd2,
    ST_SEL      = 4'd3,
    ST_DWELL    = 4'd4,
    ST_REMASK   = 4'd5,
    ST_NEXT     = 4'd6,
    ST_FINISH   = 4'd7
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/mask_cmd_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mask_cmd_issuer: one-cycle mask command pulse followed by a quiet gap;  |
// | ready is high once the gap has elapsed.                   Rev 1.0       |
// +--------------------------------------------------------------------------+
module mask_cmd_issuer
  import channel_mask_scan_controller_pkg::*;
#(
  parameter int COMMAND_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  output logic       ready,
  output logic [2:0] mask_command
);

  localparam int GW = $clog2(COMMAND_GAP + 2);

  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]    mask_command_q, mask_command_d;

  // Counter reaches zero in the last gap cycle so the next command can be
  // accepted there and pulse right after the gap.
  assign ready        = (gap_cnt_q == '0);
  assign mask_command = mask_command_q;

  always_comb begin
    mask_command_d = MASK_CMD_NONE;
    gap_cnt_d      = gap_cnt_q;
    if (!ready) begin
      gap_cnt_d = gap_cnt_q - 1'b1;
    end else if (cmd_valid) begin
      mask_command_d = cmd;
      gap_cnt_d      = GW'(COMMAND_GAP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt_q      <= '0;
      mask_command_q <= MASK_CMD_NONE;
    end else begin
      gap_cnt_q      <= gap_cnt_d;
      mask_command_q <= mask_command_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/channel_mask_scan_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | channel_mask_scan_controller: automatic per-channel discriminator scan  |
// | over the 64-channel mask register. Macro CHANNEL_SCAN_EXTTRIG_EN makes  |
// | the dwell count ExtTrigger rising edges.                  Rev 1.0       |
// +--------------------------------------------------------------------------+
module channel_mask_scan_controller
  import channel_mask_scan_controller_pkg::*;
#(
  parameter int COMMAND_GAP = 4,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   ScanStart,
  input  logic                   ScanStop,
  input  logic [5:0]             StartChannel,
  input  logic [5:0]             EndChannel,
  input  logic [2:0]             DiscriSelect,
  input  logic [DWELL_WIDTH-1:0] DwellCycles,
`ifdef CHANNEL_SCAN_EXTTRIG_EN
  input  logic                   ExtTrigger,
`endif
  output logic [5:0]             MaskChannel,
  output logic [2:0]             DiscriMask,
  output logic [2:0]             MaskCommand,
  output logic                   ChannelWindow,
  output logic [5:0]             CurrentChannel,
  output logic                   ScanBusy,
  output logic                   ScanDone
);

  scan_state_e            state_q, state_d;
  logic [5:0]             start_ch_q, start_ch_d, end_ch_q, end_ch_d;
  logic [5:0]             cur_ch_q, cur_ch_d, mask_channel_q, mask_channel_d;
  logic [2:0]             discri_sel_q, discri_sel_d, discri_mask_q, discri_mask_d;
  logic [DWELL_WIDTH-1:0] dwell_len_q, dwell_len_d, dwell_cnt_q, dwell_cnt_d;
  logic                   issued_q, issued_d, stop_pend_q, stop_pend_d;
  logic                   window_q, window_d, busy_q, busy_d, done_q, done_d;
  logic                   cmd_valid, cmd_ready, cmd_done, stop_now, dwell_tick, is_cmd_state;
  logic [2:0]             cmd;

`ifdef CHANNEL_SCAN_EXTTRIG_EN
  logic trig_prev_q;
  assign dwell_tick = ExtTrigger & ~trig_prev_q;
`else
  assign dwell_tick = 1'b1;
`endif

  mask_cmd_issuer #(.COMMAND_GAP(COMMAND_GAP)) u_issuer (
    .clk          (Clk),
    .rst          (reset),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .ready        (cmd_ready),
    .mask_command (MaskCommand)
  );

  always_comb begin
    state_d        = state_q;
    start_ch_d     = start_ch_q;
    end_ch_d       = end_ch_q;
    cur_ch_d       = cur_ch_q;
    mask_channel_d = mask_channel_q;
    discri_sel_d   = discri_sel_q;
    discri_mask_d  = discri_mask_q;
    dwell_len_d    = dwell_len_q;
    dwell_cnt_d    = dwell_cnt_q;
    issued_d       = issued_q;
    stop_pend_d    = stop_pend_q;
    window_d       = window_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    cmd            = MASK_CMD_NONE;
    is_cmd_state   = 1'b1;
    case (state_q)
      ST_MASK_ALL:       cmd = MASK_CMD_ALL;
      ST_UNMASK:         cmd = MASK_CMD_UNMASK;
      ST_SEL, ST_REMASK: cmd = MASK_CMD_MASK;
      ST_FINISH:         cmd = MASK_CMD_CLEAR;
      default:           is_cmd_state = 1'b0;
    endcase
    // Command states fire once, then hold outputs until the gap has elapsed.
    cmd_valid = is_cmd_state && !issued_q;
    if (cmd_valid && cmd_ready) issued_d = 1'b1;
    cmd_done = is_cmd_state && issued_q && cmd_ready;
    if (cmd_done) issued_d = 1'b0;
    stop_now = stop_pend_q || ScanStop;
    if (ScanStop && state_q != ST_IDLE && state_q != ST_FINISH) stop_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (ScanStart) begin
          start_ch_d     = StartChannel;
          end_ch_d       = EndChannel;
          discri_sel_d   = DiscriSelect;
          dwell_len_d    = (DwellCycles == '0) ? DWELL_WIDTH'(1) : DwellCycles;
          cur_ch_d       = StartChannel;
          mask_channel_d = StartChannel;
          discri_mask_d  = DISCRI_ALL_MASKED;
          stop_pend_d    = 1'b0;
          busy_d         = 1'b1;
          state_d        = ST_MASK_ALL;
        end
      end
      ST_MASK_ALL, ST_NEXT: begin
        if ((state_q == ST_MASK_ALL && cmd_done) || state_q == ST_NEXT) begin
          if (stop_now || (state_q == ST_NEXT && cur_ch_q == end_ch_q)) begin
            state_d       = ST_FINISH;
            discri_mask_d = DISCRI_ALL_MASKED;
          end else begin
            cur_ch_d       = (state_q == ST_NEXT) ? cur_ch_q + 6'd1 : start_ch_q;
            mask_channel_d = cur_ch_d;
            discri_mask_d  = DISCRI_NONE_MASKED;
            state_d        = ST_UNMASK;
          end
        end
      end
      ST_UNMASK, ST_SEL: begin
        if (cmd_done) begin
          if (stop_now) begin
            state_d       = ST_FINISH;
            discri_mask_d = DISCRI_ALL_MASKED;
          end else if (state_q == ST_UNMASK && discri_sel_q != DISCRI_NONE_MASKED) begin
            state_d       = ST_SEL;
            discri_mask_d = discri_sel_q;
          end else begin
            state_d     = ST_DWELL;
            window_d    = 1'b1;
            dwell_cnt_d = dwell_len_q;
          end
        end
      end
      ST_DWELL: begin
        if (ScanStop) begin
          window_d      = 1'b0;
          state_d       = ST_FINISH;
          discri_mask_d = DISCRI_ALL_MASKED;
        end else if (dwell_tick) begin
          if (dwell_cnt_q == DWELL_WIDTH'(1)) begin
            window_d      = 1'b0;
            state_d       = ST_REMASK;
            discri_mask_d = DISCRI_ALL_MASKED;
          end else begin
            dwell_cnt_d = dwell_cnt_q - 1'b1;
          end
        end
      end
      ST_REMASK: begin
        if (cmd_done) begin
          if (stop_now) state_d = ST_FINISH;
          else          state_d = ST_NEXT;
        end
      end
      ST_FINISH: begin
        if (cmd_done) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      start_ch_q     <= '0;
      end_ch_q       <= '0;
      cur_ch_q       <= '0;
      mask_channel_q <= '0;
      discri_sel_q   <= '0;
      discri_mask_q  <= '0;
      dwell_len_q    <= '0;
      dwell_cnt_q    <= '0;
      issued_q       <= 1'b0;
      stop_pend_q    <= 1'b0;
      window_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef CHANNEL_SCAN_EXTTRIG_EN
      trig_prev_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      start_ch_q     <= start_ch_d;
      end_ch_q       <= end_ch_d;
      cur_ch_q       <= cur_ch_d;
      mask_channel_q <= mask_channel_d;
      discri_sel_q   <= discri_sel_d;
      discri_mask_q  <= discri_mask_d;
      dwell_len_q    <= dwell_len_d;
      dwell_cnt_q    <= dwell_cnt_d;
      issued_q       <= issued_d;
      stop_pend_q    <= stop_pend_d;
      window_q       <= window_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
`ifdef CHANNEL_SCAN_EXTTRIG_EN
      trig_prev_q    <= ExtTrigger;
`endif
    end
  end

  assign MaskChannel    = mask_channel_q;
  assign DiscriMask     = discri_mask_q;
  assign ChannelWindow  = window_q;
  assign CurrentChannel = cur_ch_q;
  assign ScanBusy       = busy_q;
  assign ScanDone       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_channel_mask_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_channel_mask_scan_controller: randomized scans against a channel-list |
// | reference model of the expected command/window sequence.  Rev 1.0        |
// +--------------------------------------------------------------------------+
module tb_channel_mask_scan_controller;

  localparam int GAP = 4;
  localparam int DW  = 16;

  typedef struct packed {
    logic [2:0] cmd;
    logic [5:0] ch;
    logic [2:0] dm;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ScanStart, ScanStop;
  logic [5:0]    StartChannel, EndChannel;
  logic [2:0]    DiscriSelect;
  logic [DW-1:0] DwellCycles;
  logic [5:0]    MaskChannel, CurrentChannel;
  logic [2:0]    DiscriMask, MaskCommand;
  logic          ChannelWindow, ScanBusy, ScanDone;

  int checks = 0;
  int errors = 0;

`ifdef CHANNEL_SCAN_EXTTRIG_EN
  logic ExtTrigger;
  logic trig_auto = 1'b1;
  logic trig_man  = 1'b0;
  logic auto_tog  = 1'b0;
  int   tog_cnt   = 0;
  assign ExtTrigger = trig_auto ? auto_tog : trig_man;
  always @(negedge clk) begin
    tog_cnt++;
    if (tog_cnt % 4 == 0) auto_tog = ~auto_tog;
  end
`endif

  channel_mask_scan_controller #(.COMMAND_GAP(GAP), .DWELL_WIDTH(DW)) dut (
    .Clk            (clk),
    .reset          (rst),
    .ScanStart      (ScanStart),
    .ScanStop       (ScanStop),
    .StartChannel   (StartChannel),
    .EndChannel     (EndChannel),
    .DiscriSelect   (DiscriSelect),
    .DwellCycles    (DwellCycles),
`ifdef CHANNEL_SCAN_EXTTRIG_EN
    .ExtTrigger     (ExtTrigger),
`endif
    .MaskChannel    (MaskChannel),
    .DiscriMask     (DiscriMask),
    .MaskCommand    (MaskCommand),
    .ChannelWindow  (ChannelWindow),
    .CurrentChannel (CurrentChannel),
    .ScanBusy       (ScanBusy),
    .ScanDone       (ScanDone)
  );

  always #5 clk = ~clk;

  function automatic cmd_t mk(input logic [2:0] c, input logic [5:0] ch, input logic [2:0] d);
    cmd_t t;
    t.cmd = c;
    t.ch  = ch;
    t.dm  = d;
    return t;
  endfunction

  // Observation of the DUT, sampled on the falling edge.
  cmd_t       got_q[$];
  int         win_len_q[$];
  int         win_ch_q[$];
  int         done_cnt, min_gap, last_cmd, setup_err, win_run;
  int         cyc = 0;
  int         clr_req = 0;
  int         clr_seen = -1;
  logic [5:0] prev_ch = '0;
  logic [2:0] prev_dm = '0;

  always @(negedge clk) begin
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      got_q.delete();
      win_len_q.delete();
      win_ch_q.delete();
      done_cnt = 0; min_gap = 1000; last_cmd = -1; setup_err = 0; win_run = 0;
    end
    cyc++;
    if (MaskCommand !== 3'b000) begin
      if (last_cmd >= 0 && (cyc - last_cmd - 1) < min_gap) min_gap = cyc - last_cmd - 1;
      if (MaskChannel !== prev_ch || DiscriMask !== prev_dm) setup_err++;
      got_q.push_back(mk(MaskCommand, MaskChannel, DiscriMask));
      last_cmd = cyc;
    end else if (last_cmd >= 0 && (cyc - last_cmd) <= GAP) begin
      if (MaskChannel !== prev_ch || DiscriMask !== prev_dm) setup_err++;
    end
    if (ChannelWindow === 1'b1) begin
      if (win_run == 0) win_ch_q.push_back(int'(CurrentChannel));
      win_run++;
    end else if (win_run > 0) begin
      win_len_q.push_back(win_run);
      win_run = 0;
    end
    if (ScanDone === 1'b1) done_cnt++;
    prev_ch = MaskChannel;
    prev_dm = DiscriMask;
  end

  task automatic clear_monitor();
    clr_req++;
    repeat (2) @(negedge clk);
  endtask

  // Full scan with optional stop (stop_k = index in scan order, stop_win = window clock).
  task automatic run_scan(input string name, input int s, input int e, input int ds, input int dw,
                          input int stop_k, input int stop_win, input bit mid_start, input bit stop_with_start);
    cmd_t exp_q[$];
    int   exp_win[$];
    int   exp_wch[$];
    int   n, dwe, ch, wcnt, stop_ch, lim;
    bit   fin;
    n   = ((e - s + 64) % 64) + 1;
    dwe = (dw == 0) ? 1 : dw;
    exp_q.push_back(mk(3'b100, 6'd0, 3'd0));
    for (int k = 0; k < n; k++) begin
      ch = (s + k) % 64;
      exp_q.push_back(mk(3'b010, 6'(ch), 3'b111));
      if (ds != 7) exp_q.push_back(mk(3'b001, 6'(ch), 3'(ds)));
      exp_wch.push_back(ch);
      if (stop_k == k) begin
        exp_win.push_back(stop_win);
        break;
      end
      exp_win.push_back(dwe);
      exp_q.push_back(mk(3'b001, 6'(ch), 3'b000));
    end
    exp_q.push_back(mk(3'b011, 6'd0, 3'd0));
    stop_ch = (s + stop_k) % 64;

    clear_monitor();
    StartChannel = 6'(s); EndChannel = 6'(e); DiscriSelect = 3'(ds); DwellCycles = DW'(dw);
    ScanStart = 1'b1; ScanStop = stop_with_start;
    @(negedge clk);
    ScanStart = 1'b0; ScanStop = 1'b0;
    StartChannel = 6'($urandom); EndChannel = 6'($urandom);
    DiscriSelect = 3'($urandom); DwellCycles = DW'($urandom);
    checks++;
    if (ScanBusy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b want 1", name, ScanBusy); end

    fin = 0; wcnt = 0;
    for (int c = 0; c < 20000 && !fin; c++) begin
      @(negedge clk);
      ScanStop = 1'b0; ScanStart = 1'b0;
      if (ScanDone === 1'b1) fin = 1;
      else begin
        if (stop_k >= 0 && ChannelWindow === 1'b1 && int'(CurrentChannel) == stop_ch) begin
          wcnt++;
          if (wcnt == stop_win) ScanStop = 1'b1;
        end
        if (mid_start && c == 30) ScanStart = 1'b1;
      end
    end
    checks++;
    if (!fin) begin errors++; $display("FAIL %s done_timeout: got no ScanDone want pulse", name); end
    checks++;
    if (ScanBusy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b want 0", name, ScanBusy); end
    repeat (6) @(negedge clk);

    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s cmd_count: got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      checks++;
      if (got_q[i].cmd !== exp_q[i].cmd ||
          ((exp_q[i].cmd == 3'b010 || exp_q[i].cmd == 3'b001) &&
           (got_q[i].ch !== exp_q[i].ch || got_q[i].dm !== exp_q[i].dm))) begin
        errors++;
        $display("FAIL %s cmd[%0d]: got cmd=%b ch=%0d dm=%b want cmd=%b ch=%0d dm=%b", name, i,
                 got_q[i].cmd, got_q[i].ch, got_q[i].dm, exp_q[i].cmd, exp_q[i].ch, exp_q[i].dm);
      end
    end
    checks++;
    if (win_len_q.size() != exp_win.size()) begin
      errors++; $display("FAIL %s window_count: got %0d want %0d", name, win_len_q.size(), exp_win.size());
    end else begin
      for (int i = 0; i < exp_win.size(); i++) begin
        checks++;
`ifdef CHANNEL_SCAN_EXTTRIG_EN
        if (win_ch_q[i] != exp_wch[i]) begin
`else
        if (win_ch_q[i] != exp_wch[i] || win_len_q[i] != exp_win[i]) begin
`endif
          errors++;
          $display("FAIL %s window[%0d]: got ch=%0d len=%0d want ch=%0d len=%0d", name, i,
                   win_ch_q[i], win_len_q[i], exp_wch[i], exp_win[i]);
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt); end
    checks++;
    if (min_gap < GAP) begin errors++; $display("FAIL %s command_gap: got %0d want >=%0d", name, min_gap, GAP); end
    checks++;
    if (setup_err != 0) begin errors++; $display("FAIL %s chan_discri_stability: got %0d changes want 0", name, setup_err); end
  endtask

  task automatic test_reset();
    rst = 1'b1; ScanStart = 0; ScanStop = 0;
    StartChannel = 0; EndChannel = 0; DiscriSelect = 0; DwellCycles = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({MaskChannel, DiscriMask, MaskCommand, ChannelWindow, CurrentChannel, ScanBusy, ScanDone} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {MaskChannel, DiscriMask, MaskCommand, ChannelWindow, CurrentChannel, ScanBusy, ScanDone});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    run_scan("basic_5_7", 5, 7, 7, 10, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_sel_single();
    run_scan("sel_ch63", 63, 63, 5, 6, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    run_scan("wrap_62_1", 62, 1, 7, 3, -1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_stop();
    run_scan("stop_ch2", 0, 5, 7, 10, 2, 3, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_scan("mid_start", 10, 12, 3, 4, -1, 0, 1'b1, 1'b0);
    run_scan("zero_dwell", 20, 21, 7, 0, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int s, e, ds, dw, dwe, sk, sw;
    for (int r = 0; r < 6; r++) begin
      s  = int'($urandom_range(63));
      e  = (s + int'($urandom_range(5))) % 64;
      ds = int'($urandom_range(7));
      dw = int'($urandom_range(6));
      dwe = (dw == 0) ? 1 : dw;
      sk = ($urandom_range(1) == 1) ? int'($urandom_range(3)) : -1;
      sw = int'($urandom_range(1, dwe));
      run_scan($sformatf("random%0d", r), s, e, ds, dw, sk, sw, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_monitor();
    StartChannel = 0; EndChannel = 3; DiscriSelect = 7; DwellCycles = 20;
    ScanStart = 1'b1;
    @(negedge clk);
    ScanStart = 1'b0;
    ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (ChannelWindow === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_mid window_timeout: got no window want window"); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({MaskChannel, DiscriMask, MaskCommand, ChannelWindow, CurrentChannel, ScanBusy, ScanDone} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid async_outputs: got %h want 0",
               {MaskChannel, DiscriMask, MaskCommand, ChannelWindow, CurrentChannel, ScanBusy, ScanDone});
    end
    @(negedge clk);
    rst = 1'b0;
    clr_req++;
    repeat (12) @(negedge clk);
    checks++;
    if (ScanBusy !== 1'b0 || ChannelWindow !== 1'b0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid idle_after: got busy=%b win=%b cmds=%0d want 0 0 0", ScanBusy, ChannelWindow, got_q.size());
    end
    run_scan("after_reset", 40, 41, 6, 2, -1, 0, 1'b0, 1'b0);
  endtask

`ifdef CHANNEL_SCAN_EXTTRIG_EN
  task automatic test_exttrig();
    bit ok;
    trig_auto = 1'b0; trig_man = 1'b0;
    clear_monitor();
    StartChannel = 10; EndChannel = 10; DiscriSelect = 7; DwellCycles = 3;
    ScanStart = 1'b1;
    @(negedge clk);
    ScanStart = 1'b0;
    @(negedge clk);
    trig_man = 1'b1;
    @(negedge clk);
    trig_man = 1'b0;
    ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (ChannelWindow === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL exttrig window_timeout: got no window want window"); end
    for (int k = 1; k <= 3; k++) begin
      repeat (3) @(negedge clk);
      checks++;
      if (ChannelWindow !== 1'b1) begin errors++; $display("FAIL exttrig open_before_edge%0d: got %b want 1", k, ChannelWindow); end
      trig_man = 1'b1;
      @(negedge clk);
      trig_man = 1'b0;
    end
    checks++;
    if (ChannelWindow !== 1'b0) begin errors++; $display("FAIL exttrig closed_after_edge3: got %b want 0", ChannelWindow); end
    ok = 0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (ScanDone === 1'b1) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL exttrig done_timeout: got no ScanDone want pulse"); end
    trig_auto = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_sel_single();
    test_wrap();
    test_stop();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef CHANNEL_SCAN_EXTTRIG_EN
    test_exttrig();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
